// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one write port and one combinational read port between two clients each; grants same cycle.
// Read data returns registered one cycle after grant; losers hold req and win next cycle, ports never block each other.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 10,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              wr_req,
  input  logic [2*ADDR_WIDTH-1:0] wr_addr,
  input  logic [2*DATA_WIDTH-1:0] wr_data,
  output logic [1:0]              wr_gnt,
  input  logic [1:0]              rd_req,
  input  logic [2*ADDR_WIDTH-1:0] rd_addr,
  output logic [1:0]              rd_gnt,
  output logic [1:0]              rd_valid,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    mem_w_en,
  output logic [ADDR_WIDTH-1:0]   mem_w_addr,
  output logic [DATA_WIDTH-1:0]   mem_w_data,
  output logic [ADDR_WIDTH-1:0]   mem_r_addr,
  input  logic [DATA_WIDTH-1:0]   mem_r_data
);

  logic                  wr_prio_q, wr_prio_d;
  logic                  rd_prio_q, rd_prio_d;
  logic [1:0]            rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  collide;

  // Grants are forced low during reset so nothing reaches the memory.
  always_comb begin
    wr_gnt = 2'b00;
    rd_gnt = 2'b00;
    if (rst_n) begin
      if (wr_req == 2'b11) wr_gnt = wr_prio_q ? 2'b10 : 2'b01;
      else                 wr_gnt = wr_req;
      if (rd_req == 2'b11) rd_gnt = rd_prio_q ? 2'b10 : 2'b01;
      else                 rd_gnt = rd_req;
    end
  end

  // Pointer moves to the client that did not win, so a waiting loser goes next.
  always_comb begin
    wr_prio_d = wr_prio_q;
    rd_prio_d = rd_prio_q;
    if (wr_gnt[0])      wr_prio_d = 1'b1;
    else if (wr_gnt[1]) wr_prio_d = 1'b0;
    if (rd_gnt[0])      rd_prio_d = 1'b1;
    else if (rd_gnt[1]) rd_prio_d = 1'b0;
  end

  always_comb begin
    mem_w_en   = |wr_gnt;
    mem_w_addr = wr_gnt[1] ? wr_addr[ADDR_WIDTH +: ADDR_WIDTH] : wr_addr[0 +: ADDR_WIDTH];
    mem_w_data = wr_gnt[1] ? wr_data[DATA_WIDTH +: DATA_WIDTH] : wr_data[0 +: DATA_WIDTH];
    mem_r_addr = rd_gnt[1] ? rd_addr[ADDR_WIDTH +: ADDR_WIDTH] : rd_addr[0 +: ADDR_WIDTH];
  end

  assign collide = mem_w_en && (|rd_gnt) && (mem_w_addr == mem_r_addr);

  always_comb begin
    rd_valid_d = rd_gnt;
    rd_data_d  = rd_data_q;
    if (|rd_gnt) begin
      if (BYPASS && collide) rd_data_d = mem_w_data;
      else                   rd_data_d = mem_r_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_prio_q  <= 1'b0;
      rd_prio_q  <= 1'b0;
      rd_valid_q <= 2'b00;
      rd_data_q  <= '0;
    end else begin
      wr_prio_q  <= wr_prio_d;
      rd_prio_q  <= rd_prio_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: two arbiter instances (bypass on/off) sharing stimulus, each with its own memory model.
module tb_mem_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    wr_req, rd_req;
  logic [2*AW-1:0] wr_addr, rd_addr;
  logic [2*DW-1:0] wr_data;

  logic [1:0]    b1_wr_gnt, b1_rd_gnt, b1_rd_valid;
  logic [DW-1:0] b1_rd_data, b1_w_data, b1_r_data;
  logic [AW-1:0] b1_w_addr, b1_r_addr;
  logic          b1_w_en;
  logic [1:0]    b0_wr_gnt, b0_rd_gnt, b0_rd_valid;
  logic [DW-1:0] b0_rd_data, b0_w_data, b0_r_data;
  logic [AW-1:0] b0_w_addr, b0_r_addr;
  logic          b0_w_en;

  logic [DW-1:0] mem1 [16];
  logic [DW-1:0] mem0 [16];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b1)) u_byp1 (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(b1_wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(b1_rd_gnt),
    .rd_valid(b1_rd_valid), .rd_data(b1_rd_data),
    .mem_w_en(b1_w_en), .mem_w_addr(b1_w_addr), .mem_w_data(b1_w_data),
    .mem_r_addr(b1_r_addr), .mem_r_data(b1_r_data)
  );

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b0)) u_byp0 (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(b0_wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(b0_rd_gnt),
    .rd_valid(b0_rd_valid), .rd_data(b0_rd_data),
    .mem_w_en(b0_w_en), .mem_w_addr(b0_w_addr), .mem_w_data(b0_w_data),
    .mem_r_addr(b0_r_addr), .mem_r_data(b0_r_data)
  );

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem1[i] = '0;
      mem0[i] = '0;
    end
  end

  always @(posedge clk) begin
    if (b1_w_en) mem1[b1_w_addr] <= b1_w_data;
    if (b0_w_en) mem0[b0_w_addr] <= b0_w_data;
  end
  assign b1_r_data = mem1[b1_r_addr];
  assign b0_r_data = mem0[b0_r_addr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; wr_req = '0; rd_req = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    repeat (2) edge_wait();
    chk("rst_wr_gnt", b1_wr_gnt, 2'b00);
    chk("rst_rd_valid", b1_rd_valid, 2'b00);
    chk("rst_rd_data", b1_rd_data, 0);
    chk("rst_w_en", b1_w_en, 1'b0);
    wr_req = 2'b11; rd_req = 2'b11; #1;
    chk("rst_req_wr_gnt", b1_wr_gnt, 2'b00);
    chk("rst_req_rd_gnt", b1_rd_gnt, 2'b00);
    wr_req = '0; rd_req = '0;
    rst_n = 1'b1;

    // single write then a read of the same word by the other read client
    wr_req = 2'b01; wr_addr = {4'd0, 4'd5}; wr_data = {32'h0, 32'hA5}; #1;
    chk("t1_wr_gnt", b1_wr_gnt, 2'b01);
    chk("t1_w_en", b1_w_en, 1'b1);
    chk("t1_w_addr", b1_w_addr, 5);
    chk("t1_w_data", b1_w_data, 32'hA5);
    edge_wait();
    wr_req = 2'b00; rd_req = 2'b10; rd_addr = {4'd5, 4'd0}; #1;
    chk("t1_rd_gnt", b1_rd_gnt, 2'b10);
    chk("t1_r_addr", b1_r_addr, 5);
    chk("t1_rd_valid_early", b1_rd_valid, 2'b00);
    edge_wait();
    chk("t1_rd_valid", b1_rd_valid, 2'b10);
    chk("t1_rd_data", b1_rd_data, 32'hA5);
    rd_req = 2'b00;

    // client 1 seeds word 7 with 0x11; also moves wr pointer back to client 0
    wr_req = 2'b10; wr_addr = {4'd7, 4'd0}; wr_data = {32'h11, 32'h0}; #1;
    chk("seed_wr_gnt", b1_wr_gnt, 2'b10);
    chk("seed_w_addr", b1_w_addr, 7);
    edge_wait();
    chk("seed_rd_valid_idle", b1_rd_valid, 2'b00);

    // both writers continuously
    wr_req = 2'b11; wr_addr = {4'd2, 4'd1}; wr_data = {32'h2222_0002, 32'h1111_0001};
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_wr_gnt", b1_wr_gnt, (i % 2) ? 2'b10 : 2'b01);
      chk("t2_w_data", b1_w_data, (i % 2) ? 32'h2222_0002 : 32'h1111_0001);
      edge_wait();
    end
    wr_req = 2'b00;

    rd_req = 2'b11; rd_addr = {4'd2, 4'd1}; #1;
    chk("t2_rd_gnt0", b1_rd_gnt, 2'b01);
    edge_wait();
    chk("t2_rd_valid0", b1_rd_valid, 2'b01);
    chk("t2_rd_data0", b1_rd_data, 32'h1111_0001);
    #1;
    chk("t2_rd_gnt1", b1_rd_gnt, 2'b10);
    edge_wait();
    chk("t2_rd_valid1", b1_rd_valid, 2'b10);
    chk("t2_rd_data1", b1_rd_data, 32'h2222_0002);

    // both readers, then client 0 drops
    #1;
    chk("t3_rd_gnt_both", b1_rd_gnt, 2'b01);
    edge_wait();
    chk("t3_rd_valid_both", b1_rd_valid, 2'b01);
    rd_req = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_rd_gnt", b1_rd_gnt, 2'b10);
      edge_wait();
      chk("t3_rd_valid", b1_rd_valid, 2'b10);
      chk("t3_rd_data", b1_rd_data, 32'h2222_0002);
    end
    rd_req = 2'b00;

    // same-cycle write and read of word 7
    wr_req = 2'b01; wr_addr = {4'd0, 4'd7}; wr_data = {32'h0, 32'h3C};
    rd_req = 2'b01; rd_addr = {4'd0, 4'd7}; #1;
    chk("t4_wr_gnt", b1_wr_gnt, 2'b01);
    chk("t4_rd_gnt", b1_rd_gnt, 2'b01);
    edge_wait();
    chk("t4_byp1_data", b1_rd_data, 32'h3C);
    chk("t4_byp0_data", b0_rd_data, 32'h11);
    chk("t4_byp0_valid", b0_rd_valid, 2'b01);
    wr_req = 2'b00; #1;
    edge_wait();
    chk("t4_byp0_after", b0_rd_data, 32'h3C);
    rd_req = 2'b00;

    // idle cycles: nothing moves, pointers hold (both now favour client 1)
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t6_w_en", b1_w_en, 1'b0);
      chk("t6_rd_gnt", b1_rd_gnt, 2'b00);
      edge_wait();
      chk("t6_rd_valid", b1_rd_valid, 2'b00);
      chk("t6_rd_data_hold", b1_rd_data, 32'h3C);
    end
    wr_req = 2'b11; wr_addr = {4'd9, 4'd8}; wr_data = {32'h99, 32'h88};
    rd_req = 2'b11; rd_addr = {4'd2, 4'd1}; #1;
    chk("t6_wr_prio_held", b1_wr_gnt, 2'b10);
    chk("t6_rd_prio_held", b1_rd_gnt, 2'b10);
    edge_wait();
    chk("t6_rd_valid_after", b1_rd_valid, 2'b10);
    chk("t6_rd_data_after", b1_rd_data, 32'h2222_0002);

    // reset mid-operation with both ports busy
    #1;
    chk("t5_wr_gnt_pre", b1_wr_gnt, 2'b01);
    chk("t5_rd_gnt_pre", b1_rd_gnt, 2'b01);
    edge_wait();
    chk("t5_rd_valid_pre", b1_rd_valid, 2'b01);
    chk("t5_rd_data_pre", b1_rd_data, 32'h1111_0001);
    rst_n = 1'b0; #1;
    chk("t5_rd_valid_rst", b1_rd_valid, 2'b00);
    chk("t5_rd_data_rst", b1_rd_data, 0);
    chk("t5_wr_gnt_rst", b1_wr_gnt, 2'b00);
    chk("t5_rd_gnt_rst", b1_rd_gnt, 2'b00);
    chk("t5_w_en_rst", b1_w_en, 1'b0);
    edge_wait();
    chk("t5_rd_valid_held_rst", b1_rd_valid, 2'b00);
    rst_n = 1'b1; #1;
    chk("t5_wr_gnt_post", b1_wr_gnt, 2'b01);
    chk("t5_rd_gnt_post", b1_rd_gnt, 2'b01);
    edge_wait();
    chk("t5_rd_valid_post", b1_rd_valid, 2'b01);
    chk("t5_rd_data_post", b1_rd_data, 32'h1111_0001);
    wr_req = 2'b00; rd_req = 2'b00;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the two ports of the team's dual-port matrix buffer memory (one write port, one combinational read port) between two write clients and two read clients.
- Typical clients: tile loader and result writeback on the write side; row and column streamers on the read side.
- Independent round-robin arbitration per port; registered read return with a per-client valid.
- Optional same-cycle write-to-read bypass.

Parameters:
DATA_WIDTH, 256, memory word width in bits
ADDR_WIDTH, 10, memory address width in bits
BYPASS, 1, 1 = a read colliding with a same-cycle write returns the new write data; 0 = returns the old memory contents

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
wr_req  in  2  per-client write request, held until granted
wr_addr  in  2*ADDR_WIDTH  per-client write address, client i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
wr_data  in  2*DATA_WIDTH  per-client write data, same packing
wr_gnt  out  2  one-hot write grant, combinational, same cycle as the write
rd_req  in  2  per-client read request, held until granted
rd_addr  in  2*ADDR_WIDTH  per-client read address
rd_gnt  out  2  one-hot read grant, combinational
rd_valid  out  2  per-client registered read-data valid, one cycle after grant
rd_data  out  DATA_WIDTH  registered read data, shared bus, qualified by rd_valid
mem_w_en  out  1  memory write enable
mem_w_addr  out  ADDR_WIDTH  memory write address
mem_w_data  out  DATA_WIDTH  memory write data
mem_r_addr  out  ADDR_WIDTH  memory read address
mem_r_data  in  DATA_WIDTH  memory combinational read data

Behaviour:
- Reset (async assert, sync deassert in system):
  - wr_prio = 0 and rd_prio = 0 (client 0 has priority first).
  - rd_valid = 0; rd_data = 0.
  - Grant outputs and mem_w_en = 0 while rst_n is low.
- Write arbitration (combinational from wr_req and wr_prio):
  - Only one requester: it is granted.
  - Both requesting: the client indicated by wr_prio is granted.
  - On any grant, wr_prio <= index of the non-granted client (the other one), so the loser always wins next.
  - No request: wr_prio holds.
- Write datapath:
  - mem_w_en = |wr_gnt.
  - mem_w_addr/mem_w_data = granted client's fields.
  - With no grant, mem_w_addr/mem_w_data = client 0 fields (don't-care, but must not be X).
  - The write lands at the clock edge ending the grant cycle.
- Read arbitration: identical scheme with rd_prio and rd_req.
- mem_r_addr = granted client's rd_addr; with no grant, mem_r_addr = client 0 address.
- Read return:
  - At the edge ending a grant cycle: rd_data <= mem_r_data (or the bypass value) and rd_valid <= rd_gnt.
  - Latency is exactly 1 cycle; rd_valid is one-hot or zero.
  - With no grant: rd_valid <= 0 and rd_data holds its previous value.
- Back-to-back grants to the same client are allowed when the other client is idle; a client may re-request in the cycle after its grant.
- Fairness: a continuously requesting client waits at most 1 cycle per port.
- Collision (write grant and read grant to the same address in the same cycle):
  - BYPASS=1: rd_data <= granted mem_w_data.
  - BYPASS=0: rd_data <= mem_r_data (pre-write contents).
- Write and read ports never block each other.
- The two ports are fully independent; simultaneous events on both ports are always serviced in the same cycle.
- Reset asserted mid-operation:
  - Pending rd_valid is cleared immediately (asynchronously); no stale data is delivered after reset.
  - Pointers return to 0.
  - Requests pending across reset must be re-arbitrated from scratch.
- Clients must not change addr/data while req=1 and gnt=0. A violation is a protocol error; the arbiter uses the current values.
- Widths: no arithmetic; priority pointers are 1 bit each.

Test Plan:
1. Reset, then wr_req=2'b01, addr 5, data 0xA5 -> wr_gnt=01 and mem_w_en=1 in the same cycle; memory word 5 = 0xA5. A following read by client 1 of addr 5 -> rd_valid=2'b10 one cycle after rd_gnt, rd_data=0xA5.
2. Both write clients request continuously (addr 1 and addr 2) for 4 cycles -> grants 01,10,01,10. Both reads back correct; neither client waits more than 1 cycle.
3. Both read clients request, then client 0 drops -> client 1 granted every cycle. rd_valid = 10 every cycle, each one cycle after its grant.
4. Same-cycle write addr 7 = 0x3C (old contents 0x11) and read addr 7 -> BYPASS=1: rd_data=0x3C. BYPASS=0: rd_data=0x11.
5. Assert rst_n=0 while rd_valid=01 and both ports busy -> rd_valid=0 immediately, wr_gnt=rd_gnt=0. After release with both clients requesting on a port, client 0 is granted first.
6. Idle cycles between grants -> rd_valid=0 and rd_data holds its last value; mem_w_en=0; priority pointers unchanged.
